// File: rtl/ring_osc_freq_meter_if.sv
// Signal bundle between the ring-oscillator frequency meter and its user:
// control inputs, raw oscillator pins, ring enables and the measurement result.
interface ring_osc_freq_meter_if #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned GATE_W = 16
);
  logic [N_CH-1:0]         osc_in;
  logic [$clog2(N_CH)-1:0] ch_sel;
  logic [GATE_W-1:0]       gate_len;
  logic                    start;
  logic                    cont;
  logic                    abort;
  logic [N_CH-1:0]         osc_en;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        count;
  logic                    overflow;

  modport master (
    output osc_in, ch_sel, gate_len, start, cont, abort,
    input  osc_en, busy, done, count, overflow
  );

  modport slave (
    input  osc_in, ch_sel, gate_len, start, cont, abort,
    output osc_en, busy, done, count, overflow
  );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: enables one ring, lets it settle, then counts
// synchronized rising edges over a programmable gate window with a saturating counter.
module ring_osc_freq_meter #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned GATE_W     = 16,
  parameter int unsigned SETTLE_CYC = 8
) (
  input logic                  clk,
  input logic                  rst,
  ring_osc_freq_meter_if.slave bus
);
  localparam int unsigned SelW = $clog2(N_CH);
  localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TmrW = (GATE_W > SetW) ? GATE_W : SetW;
  localparam logic [TmrW-1:0]  SettleLoad = TmrW'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure} state_e;

  state_e            state_q, state_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, count_q, count_d, cnt_inc;
  logic              ovf_q, ovf_d, overflow_q, overflow_d, ovf_inc;
  logic              done_q, done_d;
  logic              s1_q, s2_q, s3_q;
  logic              rise, last;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gate_d     = gate_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    last       = (tmr_q == TmrW'(1));

    // Saturating increment; an edge arriving at full scale only raises the flag.
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    if (rise) begin
      if (cnt_q == CntMax) ovf_inc = 1'b1;
      else                 cnt_inc = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          sel_d   = bus.ch_sel;
          gate_d  = (bus.gate_len == '0) ? GATE_W'(1) : bus.gate_len;
          tmr_d   = SettleLoad;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (last) begin
          tmr_d   = TmrW'(gate_q);
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StMeasure;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StMeasure: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          ovf_d = ovf_inc;
          if (last) begin
            count_d    = cnt_inc;
            overflow_d = ovf_inc;
            done_d     = 1'b1;
            if (bus.cont) begin
              tmr_d   = SettleLoad;
              state_d = StSettle;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      gate_q     <= '0;
      tmr_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gate_q     <= gate_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      // Free-running so the history FF is primed before counting begins.
      s1_q       <= bus.osc_in[sel_q];
      s2_q       <= s1_q;
      s3_q       <= s2_q;
    end
  end

  // Combinational from reset-cleared state so the ring drops on rst without a clock.
  assign bus.osc_en   = (state_q != StIdle) ? (N_CH'(1) << sel_q) : '0;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Self-checking bench for ring_osc_freq_meter: directed and randomized measurements
// compared against an edge-counting model over the recorded oscillator waveform.
module tb_ring_osc_freq_meter;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GATE_W = 16;
  localparam int          S      = 8;
  localparam int          SelW   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ring_osc_freq_meter_if #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W)) bus ();
  ring_osc_freq_meter_if #(.N_CH(N_CH), .CNT_W(4), .GATE_W(GATE_W)) bus4 ();

  assign bus4.osc_in   = bus.osc_in;
  assign bus4.ch_sel   = bus.ch_sel;
  assign bus4.gate_len = bus.gate_len;
  assign bus4.start    = bus.start;
  assign bus4.cont     = bus.cont;
  assign bus4.abort    = bus.abort;

  ring_osc_freq_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .GATE_W(GATE_W), .SETTLE_CYC(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ring_osc_freq_meter #(.N_CH(N_CH), .CNT_W(4), .GATE_W(GATE_W), .SETTLE_CYC(S)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [N_CH-1:0] hist [16384];
  int  half [N_CH];
  int  ph   [N_CH];
  bit  jitter = 1'b0;
  int  prev_cnt, prev_cnt4, prev_ovf4;

  // hist[c] holds the pin values sampled by posedge number c.
  always @(posedge clk) begin
    hist[cyc[13:0]] <= bus.osc_in;
    cyc             <= cyc + 1;
  end

  initial begin
    bus.osc_in = '0;
    for (int i = 0; i < N_CH; i++) ph[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N_CH; i++) begin
        if (!(jitter && half[i] > 1 && $urandom_range(0, 9) == 0)) begin
          ph[i]++;
          if (ph[i] >= half[i]) begin
            ph[i]         = 0;
            bus.osc_in[i] = ~bus.osc_in[i];
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Rising edges whose detection cycle (one after the sample) lies in MEASURE [m0, m0+g-1].
  function automatic int exp_edges(input int ch, input int m0, input int g);
    int e = 0;
    for (int c = m0 - 1; c <= m0 + g - 2; c++) begin
      logic [13:0] a, b;
      logic [1:0]  k;
      a = 14'(c);
      b = 14'(c - 1);
      k = 2'(ch);
      if (hist[a][k] === 1'b1 && hist[b][k] === 1'b0) e++;
    end
    return e;
  endfunction

  function automatic int sat4(input int e);
    return (e > 15) ? 15 : e;
  endfunction

  // Poll until done or a bounded overrun; osc_en must stay on the latched channel.
  task automatic wait_done(input int ch, input int d, input int inj, output int seen);
    seen = -1;
    while (cyc - 1 < d + 4) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen = cyc - 1;
        break;
      end
      chk("osc_en_run", 32'(bus.osc_en), 32'(1) << ch);
      if (cyc - 1 == inj) begin
        bus.start  = 1'b1;
        bus.ch_sel = SelW'((ch + 1) % N_CH);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("done_cycle", seen, d);
  endtask

  task automatic launch(input int ch, input int glen, input bit cmode, output int t);
    @(negedge clk);
    bus.ch_sel   = SelW'(ch);
    bus.gate_len = GATE_W'(glen);
    bus.cont     = cmode;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    t            = cyc - 1;
    bus.start    = 1'b0;
    bus.ch_sel   = SelW'((ch + 2) % N_CH);
    bus.gate_len = GATE_W'($urandom_range(1, 3));
    chk("busy_start", 32'(bus.busy), 32'(1));
    chk("osc_en_start", 32'(bus.osc_en), 32'(1) << ch);
  endtask

  task automatic single(input int ch, input int glen, input int inj_off);
    int t, g, d, seen, e, inj;
    launch(ch, glen, 1'b0, t);
    g   = (glen == 0) ? 1 : glen;
    d   = t + S + g;
    inj = (inj_off >= 0) ? t + S + inj_off : -1;
    wait_done(ch, d, inj, seen);
    e = exp_edges(ch, t + S, g);
    chk("count", 32'(bus.count), e);
    chk("overflow", 32'(bus.overflow), 32'(0));
    chk("count4", 32'(bus4.count), sat4(e));
    chk("overflow4", 32'(bus4.overflow), 32'(e > 15));
    chk("busy_at_done", 32'(bus.busy), 32'(0));
    chk("osc_en_at_done", 32'(bus.osc_en), 32'(0));
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(bus.done), 32'(0));
    prev_cnt  = e;
    prev_cnt4 = sat4(e);
    prev_ovf4 = (e > 15) ? 1 : 0;
  endtask

  task automatic abort_at(input int ch, input int glen, input int off);
    int t, seen;
    launch(ch, glen, 1'b0, t);
    while (cyc - 1 < t + off) begin
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_osc_en", 32'(bus.osc_en), 32'(0));
    chk("abort_done", 32'(bus.done), 32'(0));
    chk("abort_count", 32'(bus.count), prev_cnt);
    chk("abort_count4", 32'(bus4.count), prev_cnt4);
    chk("abort_overflow4", 32'(bus4.overflow), prev_ovf4);
    seen = 0;
    repeat (glen + S + 4) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("abort_no_done", seen, 0);
  endtask

  task automatic reset_at(input int ch, input int off);
    int t;
    launch(ch, 30, 1'b0, t);
    while (cyc - 1 < t + off) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("rst_osc_en", 32'(bus.osc_en), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_overflow4", 32'(bus4.overflow), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    prev_cnt  = 0;
    prev_cnt4 = 0;
    prev_ovf4 = 0;
    @(negedge clk);
  endtask

  initial begin
    int t, seen, e, ch, glen;
    for (int i = 0; i < N_CH; i++) half[i] = 3;
    rst          = 1'b0;
    bus.ch_sel   = '0;
    bus.gate_len = '0;
    bus.start    = 1'b0;
    bus.cont     = 1'b0;
    bus.abort    = 1'b0;
    prev_cnt     = 0;
    prev_cnt4    = 0;
    prev_ovf4    = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("reset_osc_en", 32'(bus.osc_en), 32'(0));
    chk("reset_busy", 32'(bus.busy), 32'(0));
    chk("reset_done", 32'(bus.done), 32'(0));
    chk("reset_count", 32'(bus.count), 32'(0));
    chk("reset_overflow", 32'(bus.overflow), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Period-8 ring on channel 2, with a stray start on another channel mid-window.
    half[2] = 4;
    single(2, 80, 3);
    chk("single_tol", 32'(bus.count >= 9 && bus.count <= 11), 32'(1));

    abort_at(1, 40, S + 5);
    abort_at(3, 10, S + 10 - 1);
    abort_at(0, 20, 3);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", 32'(bus.busy), 32'(0));
    chk("start_abort_osc_en", 32'(bus.osc_en), 32'(0));

    // Period-2 ring saturates the 4-bit instance.
    half[0] = 1;
    single(0, 64, -1);
    chk("sat_count4", 32'(bus4.count), 32'(15));
    chk("sat_overflow4", 32'(bus4.overflow), 32'(1));

    // Continuous mode, period 4; cont cleared after the second result.
    half[1] = 2;
    launch(1, 20, 1'b1, t);
    for (int k = 0; k < 3; k++) begin
      wait_done(1, t + (k + 1) * (S + 20), -1, seen);
      e = exp_edges(1, t + (k + 1) * (S + 20) - 20, 20);
      chk("cont_count", 32'(bus.count), e);
      chk("cont_count4", 32'(bus4.count), sat4(e));
      if (k < 2) begin
        chk("cont_busy", 32'(bus.busy), 32'(1));
        chk("cont_osc_en", 32'(bus.osc_en), 32'(1) << 1);
      end else begin
        chk("cont_end_busy", 32'(bus.busy), 32'(0));
        prev_cnt  = e;
        prev_cnt4 = sat4(e);
        prev_ovf4 = (e > 15) ? 1 : 0;
      end
      if (k == 1) bus.cont = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("cont_idle", 32'(bus.busy), 32'(0));

    reset_at(2, 3);
    reset_at(2, S + 4);
    single(3, 0, -1);

    jitter = 1'b1;
    repeat (8) begin
      for (int i = 0; i < N_CH; i++) half[i] = $urandom_range(1, 6);
      ch   = $urandom_range(0, N_CH - 1);
      glen = $urandom_range(1, 50);
      single(ch, glen, (glen >= 6) ? 2 : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
